// File: rtl/div_radix2_if.sv
// rtl/div_radix2_if.sv - pipeline-to-divider handshake, operands and HI/LO result
interface div_radix2_if;
   logic        start;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        div_stall;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, div_stall
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, div_stall
   );
endinterface

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - 32-bit radix-2 restoring divider (DIV/DIVU) for the E stage
module div_radix2 (
   input  logic        clk,
   input  logic        resetn,
   div_radix2_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BYZERO = 2'd1;
   localparam logic [1:0] ON     = 2'd2;
   localparam logic [1:0] END    = 2'd3;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [64:0] rem_q;
   logic [31:0] divisor;
   logic        sgn_mode;
   logic        sign1;
   logic        sign2;
   logic [63:0] result_r;

   logic [64:0] shifted;
   logic [32:0] trial;
   logic [64:0] step;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic        ready_w;

   // One restoring step: shift, trial-subtract, keep the trial only if it did not go negative.
   always_comb begin
      shifted = rem_q << 1;
      trial   = shifted[64:32] - {1'b0, divisor};
      step    = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
      q_fix   = (sgn_mode && (sign1 ^ sign2)) ? -step[31:0] : step[31:0];
      r_fix   = (sgn_mode && sign1) ? -step[63:32] : step[63:32];
      mag1    = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
      mag2    = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cnt      <= 6'd0;
         rem_q    <= 65'd0;
         divisor  <= 32'd0;
         sgn_mode <= 1'b0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         result_r <= 64'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.annul) begin
                  if (bus.opdata2 == 32'd0) begin
                     state <= BYZERO;
                  end else begin
                     state    <= ON;
                     rem_q    <= {33'd0, mag1};
                     divisor  <= mag2;
                     sgn_mode <= bus.signed_div;
                     sign1    <= bus.opdata1[31];
                     sign2    <= bus.opdata2[31];
                     cnt      <= 6'd0;
                  end
               end
            end
            BYZERO: begin
               if (bus.annul) begin
                  state <= IDLE;
               end else begin
                  state    <= END;
                  result_r <= 64'h0;
               end
            end
            ON: begin
               if (bus.annul) begin
                  state <= IDLE;
               end else begin
                  rem_q <= step;
                  cnt   <= cnt + 6'd1;
                  // Sign fixup rides on the last step so result is final on END entry.
                  if (cnt == 6'd31) begin
                     state    <= END;
                     result_r <= {r_fix, q_fix};
                  end
               end
            end
            END: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign ready_w       = (state == END);
   assign bus.ready     = ready_w;
   assign bus.result    = result_r;
   assign bus.div_stall = bus.start & ~ready_w;

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - scoreboard bench for div_radix2 against an arithmetic reference
module tb_div_radix2;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [63:0] last_res = 64'h0;
   logic [63:0] exp_q[$];
   int          cyc_q[$];

   div_radix2_if d();

   div_radix2 dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (d)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // C-style truncating division; a zero divisor yields all zeros.
   function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'h0;
      if (sd) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   function automatic logic [31:0] pick(input bit allow_zero);
      logic [31:0] corner[4];
      corner[0] = 32'h80000000;
      corner[1] = 32'hFFFFFFFF;
      corner[2] = 32'h00000001;
      corner[3] = allow_zero ? 32'h0 : 32'h7FFFFFFF;
      case ($urandom_range(0, 3))
         0:       return corner[$urandom_range(0, 3)];
         1:       return 32'($urandom_range(0, 300)) - 32'd150;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      if (resetn && d.ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", 64'd1, 64'd0);
         end else begin
            logic [63:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            chk("result", d.result, e);
            chk("latency", 64'(cyc), 64'(c));
         end
      end
   end

   task automatic run_op(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input bit keep, input bit drop);
      logic [63:0] e;
      bit seen;
      bit stall_ok;
      @(negedge clk);
      d.start = 1'b1; d.signed_div = sd; d.opdata1 = a; d.opdata2 = b;
      e = ref_div(sd, a, b);
      exp_q.push_back(e);
      cyc_q.push_back(cyc + ((b == 32'd0) ? 2 : 33));
      seen = 1'b0;
      stall_ok = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (d.ready) begin
            seen = 1'b1;
         end else begin
            if (!drop && !d.div_stall) stall_ok = 1'b0;
            d.opdata1 = $urandom; d.opdata2 = $urandom; d.signed_div = 1'($urandom);
            if (drop) d.start = 1'b0;
         end
      end
      if (!seen) begin
         chk("ready_timeout", 64'd0, 64'd1);
         if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
         end
      end else begin
         chk("stall_at_ready", 64'(d.div_stall), 64'd0);
         if (!drop) chk("stall_while_busy", 64'(stall_ok), 64'd1);
      end
      if (!keep) d.start = 1'b0;
      last_res = e;
   endtask

   task automatic watch_quiet(input string nm);
      int pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (d.ready) pulses++;
      end
      chk({nm, "_no_ready"}, 64'(pulses), 64'd0);
      chk({nm, "_result_held"}, d.result, last_res);
   endtask

   // n==0 annuls in the start cycle itself; otherwise annul is sampled n edges after acceptance.
   task automatic run_annul(input logic [31:0] a, input logic [31:0] b, input int n, input string nm);
      @(negedge clk);
      d.start = 1'b1; d.signed_div = 1'b0; d.opdata1 = a; d.opdata2 = b;
      d.annul = (n == 0);
      repeat (n) @(negedge clk);
      if (n > 0) begin
         d.start = 1'b0;
         d.annul = 1'b1;
      end
      @(negedge clk);
      d.start = 1'b0;
      d.annul = 1'b0;
      watch_quiet(nm);
   endtask

   task automatic run_reset();
      @(negedge clk);
      d.start = 1'b1; d.signed_div = 1'b1; d.opdata1 = 32'h00ABCDEF; d.opdata2 = 32'd13;
      repeat (15) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("midrst_result", d.result, 64'h0);
      chk("midrst_ready", 64'(d.ready), 64'd0);
      chk("midrst_stall_start", 64'(d.div_stall), 64'd1);
      d.start = 1'b0;
      #1;
      chk("midrst_stall_idle", 64'(d.div_stall), 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      last_res = 64'h0;
      watch_quiet("after_reset");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
      $fatal(1);
   end

   initial begin
      bit sd, keep, drop;
      d.start = 1'b0; d.signed_div = 1'b0; d.opdata1 = 32'd0; d.opdata2 = 32'd0; d.annul = 1'b0;
      resetn = 1'b1;
      #3 resetn = 1'b0;
      #1;
      chk("reset_result", d.result, 64'h0);
      chk("reset_ready", 64'(d.ready), 64'd0);
      chk("reset_stall_idle", 64'(d.div_stall), 64'd0);
      d.start = 1'b1;
      #1 chk("reset_stall_start", 64'(d.div_stall), 64'd1);
      d.start = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      run_op(1'b0, 32'hFFFFFFFF, 32'h00000010, 1'b0, 1'b0);
      chk("divu_ffffffff_by_16", last_res, {32'h0000000F, 32'h0FFFFFFF});
      run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0);
      run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0);
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
      chk("div_overflow_wrap", last_res, {32'h00000000, 32'h80000000});
      run_op(1'b1, 32'h00001234, 32'h00000000, 1'b0, 1'b0);
      run_op(1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
      run_op(1'b0, 32'd1000, 32'd7, 1'b0, 1'b1);

      run_annul(32'd12345, 32'd99, 10, "annul_on");
      run_annul(32'd5, 32'd0, 1, "annul_byzero");
      run_annul(32'd5, 32'd3, 0, "annul_idle");
      run_op(1'b0, 32'd12345, 32'd99, 1'b0, 1'b0);

      run_reset();

      run_op(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
      run_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0);
      run_op(1'b1, 32'd55, 32'd0, 1'b1, 1'b0);
      run_op(1'b1, 32'h80000001, 32'h80000000, 1'b0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         sd   = 1'($urandom);
         drop = ($urandom_range(0, 7) == 0);
         keep = !drop && ($urandom_range(0, 2) == 0) && (k != 29);
         run_op(sd, pick(1'b0), pick(1'b1), keep, drop);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_radix2.md
DIV_RADIX2 -- requirements
Module: div_radix2

Interface
REQ-001 SHALL have a single clock and reset: asynchronous, active-low reset; all state changes on the rising clk edge.
REQ-002 Port: clk  in  1  pipeline clock.
REQ-003 Port: resetn  in  1  async active-low reset.
REQ-004 Port: start  in  1  E-stage DIV/DIVU present; held high by the pipeline until ready.
REQ-005 Port: signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 Port: opdata1  in  32  dividend (rs value after E-stage forwarding).
REQ-007 Port: opdata2  in  32  divisor (rt value after E-stage forwarding).
REQ-008 Port: annul  in  1  abort the in-flight divide (exception/flush).
REQ-009 Port: result  out  64  {remainder[63:32], quotient[31:0]} for HI/LO.
REQ-010 Port: ready  out  1  one-cycle pulse; result is valid this cycle.
REQ-011 Port: div_stall  out  1  to hazard unit as div_stallE; holds F/D/E stages.

Function
REQ-012 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-013 IDLE: start=1 & annul=0 & opdata2==0 -> BYZERO; start=1 & annul=0 & opdata2!=0 -> ON; otherwise stay in IDLE.
REQ-014 On IDLE->ON: latch |opdata1|, |opdata2| (magnitudes when signed_div=1, raw otherwise), signed_div, and the operand signs; clear the 6-bit iteration counter.
REQ-015 ON: one restoring shift-subtract step per cycle on a 65-bit partial-remainder/quotient register; counter increments per step; after step 32 (counter==31) -> END.
REQ-016 Step rule: trial = upper 33 bits - {1'b0, divisor}; if trial is non-negative, shift in 1 and keep trial; else shift in 0 and keep the old value.
REQ-017 BYZERO: -> END next cycle with result = 64'h0.
REQ-018 END: ready=1 with final result driven; -> IDLE next cycle unconditionally.
REQ-019 Signed fixup applied at END entry: quotient negated iff the dividend and divisor signs differ; remainder takes the dividend's sign.
REQ-020 Overflow case 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-021 Latency: start sampled in IDLE at edge T -> ready high in cycle T+33 (non-zero divisor), or T+2 (zero divisor).
REQ-022 div_stall = start & ~ready (combinational); low in the END cycle so the E stage advances.
REQ-023 Operand changes while in ON/BYZERO SHALL be ignored (latched copies only).
REQ-024 annul=1 in ON or BYZERO -> IDLE next edge; no ready pulse; result unchanged.
REQ-025 annul=1 in IDLE SHALL block a start that cycle.
REQ-026 start still high in IDLE after END (back-to-back DIV) SHALL begin a new operation with the current operands.
REQ-027 The result register SHALL hold its last value outside END; it is updated only on entry to END.
REQ-028 start deasserting mid-ON (not annul) SHALL NOT abort; the operation completes and pulses ready.

Reset
REQ-029 resetn=0 SHALL asynchronously force state=IDLE, counter=0, result=64'h0, ready=0, internal registers=0.
REQ-030 div_stall during reset = start (ready=0).
REQ-031 Reset mid-ON SHALL discard the operation; after release, there is no ready pulse until a new start.

Verification
REQ-032 DIVU 0xFFFFFFFF/0x10, start held -> ready at T+33, result={0x0000000F,0x0FFFFFFF}; div_stall high for cycles T..T+32.
REQ-033 DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 7/-2 -> quotient -3, remainder 1.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> result={0x00000000,0x80000000}, ready at T+33.
REQ-035 opdata2=0 -> ready at T+2, result=64'h0, div_stall low at T+2.
REQ-036 annul pulse at T+10 of a divide -> state IDLE at T+11, no ready, previous result retained; the next start completes normally.
REQ-037 resetn low at T+15, released at T+17 -> result=0, ready never pulses; back-to-back starts complete in 33 cycles each with a one-cycle END gap.
